uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Receive-side command stage in each FPGA_modulo; sits directly downstream of uart_rx.
- Consumes bytes from the master's turn_on/turn_off command stream and drives the module's switching-enable.
- Answers every received byte through uart_tx with ACK or NACK.
- Optional watchdog forces the output off when the master goes silent.

Parameters:
- CMD_ON, 8'h2A, enable command
- CMD_OFF, 8'h93, disable command
- CMD_TOGGLE, 8'hC3, invert enable
- ACK_BYTE, 8'h6B, reply to a valid command
- NACK_BYTE, 8'hA5, reply to an unknown byte or a parity-error byte
- TIMEOUT_CYCLES, 72000000, watchdog period in clk cycles (3 s at 24 MHz); counter is 27 bits

Ports:
- clk  in  1  system clock (24 MHz HFOSC)
- reset  in  1  asynchronous, active-high reset
- data_received  in  8  byte from uart_rx
- rx_done  in  1  one-cycle strobe: data_received valid
- parity_error  in  1  qualifies rx_done; byte is corrupt
- tx_busy  in  1  uart_tx busy flag
- data_to_tx  out  8  reply byte to uart_tx
- start_tx  out  1  transmit request to uart_tx
- out_en  out  1  module enable; 1 = SPWM gates enabled
- cmd_valid  out  1  one-cycle pulse per accepted command
- cmd_error  out  1  one-cycle pulse per NACKed byte
- ack_overrun  out  1  one-cycle pulse when a pending reply is overwritten
- wdt_trip  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async assert, sync release):
  - out_en=0, start_tx=0, data_to_tx=8'h00, all pulses 0
  - state=IDLE, pend=0, watchdog counter=0
- Decode on rx_done=1 in cycle N; effects are registered and visible in cycle N+1.
  - parity_error=1: NACK, cmd_error=1, out_en unchanged.
  - CMD_ON: out_en=1, ACK, cmd_valid=1.
  - CMD_OFF: out_en=0, ACK, cmd_valid=1.
  - CMD_TOGGLE: out_en=~out_en, ACK, cmd_valid=1.
  - Any other byte: NACK, cmd_error=1, out_en unchanged.
- Decode and out_en update occur in every state; reply transmission never delays out_en.
- Reply FSM states: IDLE, ACK_REQ, ACK_BUSY.
  - IDLE: on a reply request -> ACK_REQ, with data_to_tx loaded with the reply byte.
  - ACK_REQ: start_tx=1, data_to_tx held stable; when tx_busy is sampled 1 -> ACK_BUSY, start_tx=0.
  - ACK_BUSY: start_tx=0; when tx_busy is sampled 0:
    - pend=1 -> ACK_REQ with pend_byte, pend cleared
    - otherwise -> IDLE
- Reply requests while in ACK_REQ/ACK_BUSY go to a one-deep pending register (pend, pend_byte).
  - If pend is already 1: pend_byte is overwritten with the newest reply and ack_overrun pulses.
- Simultaneous rx_done and ACK_BUSY exit:
  - pend=1: pend_byte goes to ACK_REQ; the new reply becomes pend_byte (pend stays 1, no overrun).
  - pend=0: the new reply goes straight to ACK_REQ.
- start_tx is held high until tx_busy is seen; there is no internal timeout on it, recovery is by reset.
- Reset mid-transfer: FSM returns to IDLE immediately, pend is discarded, out_en=0.

Optional Feature:
- Macro: UART_CMD_WATCHDOG_EN.
- Defined:
  - Counter increments every cycle while out_en=1.
  - Counter clears on every cmd_valid, and holds 0 while out_en=0.
  - On reaching TIMEOUT_CYCLES-1: next cycle out_en=0, wdt_trip=1 for one cycle, counter=0.
  - A valid command in the same cycle as expiry wins: command applied, no trip.
  - NACKed bytes do not clear the counter.
- Not defined: no counter logic; wdt_trip tied 0; out_en changes only by command or reset.

Test Plan:
- Reset release, rx_done with 8'h2A -> out_en=1 in cycle N+1, cmd_valid pulse, start_tx=1 with data_to_tx=8'h6B until tx_busy rises, FSM back to IDLE after tx_busy falls.
- 8'h2A then 8'hC3 twice, each byte after the previous reply completes -> out_en sequence 1,0,1; three ACKs sent.
- rx_done with 8'h55, then 8'h93 with parity_error=1 -> out_en unchanged; two NACK 8'hA5 replies; cmd_error pulses twice.
- Three commands (2A, 93, 2A) while tx_busy held high from the first reply -> out_en tracks each command immediately; ack_overrun pulses once; exactly two replies sent in total.
- Reset asserted during ACK_BUSY with pend=1 -> outputs at reset values within the same cycle; no further start_tx after release.
- With UART_CMD_WATCHDOG_EN and TIMEOUT_CYCLES=100: 8'h2A, then silence -> out_en falls exactly 100 cycles after cmd_valid, wdt_trip pulses once; an 8'h2A at cycle 99 prevents the trip.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Command decoder behind uart_rx: drives out_en from ON/OFF/TOGGLE bytes and queues ACK/NACK replies to uart_tx.
// Optional master-silence watchdog is compiled in with `define UART_CMD_WATCHDOG_EN.
module uart_cmd_decoder #(
  parameter logic [7:0] CMD_ON     = 8'h2A,
  parameter logic [7:0] CMD_OFF    = 8'h93,
  parameter logic [7:0] CMD_TOGGLE = 8'hC3,
  parameter logic [7:0] ACK_BYTE   = 8'h6B,
  parameter logic [7:0] NACK_BYTE  = 8'hA5
`ifdef UART_CMD_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 72000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_received,
  input  logic       rx_done,
  input  logic       parity_error,
  input  logic       tx_busy,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
  output logic       out_en,
  output logic       cmd_valid,
  output logic       cmd_error,
  output logic       ack_overrun,
  output logic       wdt_trip
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_REQ  = 2'd1,
    ACK_BUSY = 2'd2
  } state_t;

  state_t     state;
  logic       pend;
  logic [7:0] pend_byte;

  logic       accept;
  logic [7:0] reply;
  logic       en_cmd;
  logic       en_next;

  // Byte decode: accepted commands and the out_en they request.
  always_comb begin
    accept = 1'b0;
    en_cmd = out_en;
    if (rx_done && !parity_error) begin
      if (data_received == CMD_ON) begin
        accept = 1'b1;
        en_cmd = 1'b1;
      end else if (data_received == CMD_OFF) begin
        accept = 1'b1;
        en_cmd = 1'b0;
      end else if (data_received == CMD_TOGGLE) begin
        accept = 1'b1;
        en_cmd = ~out_en;
      end
    end
    reply = accept ? ACK_BYTE : NACK_BYTE;
  end

`ifdef UART_CMD_WATCHDOG_EN
  localparam int unsigned WDT_W = 27;

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_expire;

  // A command landing on the expiry cycle takes precedence over the trip.
  assign wdt_expire = out_en && !accept && (wdt_cnt == WDT_W'(TIMEOUT_CYCLES - 1));
  assign en_next    = wdt_expire ? 1'b0 : en_cmd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt  <= '0;
      wdt_trip <= 1'b0;
    end else begin
      wdt_trip <= wdt_expire;
      if (accept || !out_en || wdt_expire) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
    end
  end
`else
  assign en_next  = en_cmd;
  assign wdt_trip = 1'b0;
`endif

  // Enable/pulse registers plus the reply FSM with its one-deep pending slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= 1'b0;
      pend_byte   <= 8'h00;
      data_to_tx  <= 8'h00;
      start_tx    <= 1'b0;
      out_en      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_error   <= 1'b0;
      ack_overrun <= 1'b0;
    end else begin
      out_en      <= en_next;
      cmd_valid   <= accept;
      cmd_error   <= rx_done && !accept;
      ack_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done) begin
            state      <= ACK_REQ;
            data_to_tx <= reply;
            start_tx   <= 1'b1;
          end
        end
        ACK_REQ: begin
          if (tx_busy) begin
            state    <= ACK_BUSY;
            start_tx <= 1'b0;
          end
          if (rx_done) begin
            pend        <= 1'b1;
            pend_byte   <= reply;
            ack_overrun <= pend;
          end
        end
        ACK_BUSY: begin
          if (!tx_busy) begin
            if (pend) begin
              state      <= ACK_REQ;
              start_tx   <= 1'b1;
              data_to_tx <= pend_byte;
              pend       <= rx_done;
              if (rx_done) begin
                pend_byte <= reply;
              end
            end else if (rx_done) begin
              state      <= ACK_REQ;
              start_tx   <= 1'b1;
              data_to_tx <= reply;
            end else begin
              state <= IDLE;
            end
          end else if (rx_done) begin
            pend        <= 1'b1;
            pend_byte   <= reply;
            ack_overrun <= pend;
          end
        end
        default: begin
          state    <= IDLE;
          start_tx <= 1'b0;
          pend     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder with a behavioural uart_tx and a reply scoreboard.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_received = 8'h00;
  logic       rx_done = 1'b0;
  logic       parity_error = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] data_to_tx;
  logic       start_tx;
  logic       out_en;
  logic       cmd_valid;
  logic       cmd_error;
  logic       ack_overrun;
  logic       wdt_trip;

  int checks = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_obs[$];
  logic       exp_en = 1'b0;
  logic       tx_stall = 1'b0;
  int         busy_cnt = 0;
  int         cv_cnt = 0;
  int         ce_cnt = 0;
  int         ov_cnt = 0;
  int         trip_cnt = 0;

`ifdef UART_CMD_WATCHDOG_EN
  uart_cmd_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_received(data_received),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .tx_busy      (tx_busy),
    .data_to_tx   (data_to_tx),
    .start_tx     (start_tx),
    .out_en       (out_en),
    .cmd_valid    (cmd_valid),
    .cmd_error    (cmd_error),
    .ack_overrun  (ack_overrun),
    .wdt_trip     (wdt_trip)
  );
`else
  uart_cmd_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .data_received(data_received),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .tx_busy      (tx_busy),
    .data_to_tx   (data_to_tx),
    .start_tx     (start_tx),
    .out_en       (out_en),
    .cmd_valid    (cmd_valid),
    .cmd_error    (cmd_error),
    .ack_overrun  (ack_overrun),
    .wdt_trip     (wdt_trip)
  );
`endif

  always #5 clk = ~clk;

  // uart_tx model and pulse counters, all sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_valid)   cv_cnt++;
      if (cmd_error)   ce_cnt++;
      if (ack_overrun) ov_cnt++;
      if (wdt_trip)    trip_cnt++;
      if (!tx_busy && start_tx) begin
        tx_obs.push_back(data_to_tx);
        tx_busy  = 1'b1;
        busy_cnt = 4;
      end else if (tx_busy) begin
        if (busy_cnt > 0) busy_cnt--;
        else if (!tx_stall) tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic perr);
    @(negedge clk);
    data_received = b;
    parity_error  = perr;
    rx_done       = 1'b1;
    @(negedge clk);
    rx_done      = 1'b0;
    parity_error = 1'b0;
  endtask

  task automatic wait_replies(input int n, input string name);
    int k;
    k = 0;
    while (!(tx_obs.size() >= n && !tx_busy && !start_tx) && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (5) @(negedge clk);
    if (k >= 300) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d replies, need %0d", name, tx_obs.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_en !== 1'b0) begin fails++; $display("FAIL reset_out_en: got %b, want 0", out_en); end
    checks++; if (start_tx !== 1'b0) begin fails++; $display("FAIL reset_start_tx: got %b, want 0", start_tx); end
    checks++; if (data_to_tx !== 8'h00) begin fails++; $display("FAIL reset_data_to_tx: got %h, want 00", data_to_tx); end
    checks++;
    if ({cmd_valid, cmd_error, ack_overrun, wdt_trip} !== 4'b0000) begin
      fails++; $display("FAIL reset_pulses: got %b, want 0000", {cmd_valid, cmd_error, ack_overrun, wdt_trip});
    end
    #2 reset = 1'b0;
    exp_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd_on();
    int n0;
    n0 = tx_obs.size();
    exp_q.push_back(8'h6B);
    send_byte(8'h2A, 1'b0);
    exp_en = 1'b1;
    checks++; if (out_en !== exp_en) begin fails++; $display("FAIL on_out_en: got %b, want %b", out_en, exp_en); end
    checks++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL on_cmd_valid: got %b, want 1", cmd_valid); end
    checks++; if (start_tx !== 1'b1) begin fails++; $display("FAIL on_start_tx: got %b, want 1", start_tx); end
    checks++; if (data_to_tx !== 8'h6B) begin fails++; $display("FAIL on_data_to_tx: got %h, want 6b", data_to_tx); end
    @(negedge clk);
    checks++; if (start_tx !== 1'b0) begin fails++; $display("FAIL on_start_drop: got %b, want 0", start_tx); end
    wait_replies(n0 + 1, "on");
    checks++; if (start_tx !== 1'b0) begin fails++; $display("FAIL on_idle: start_tx %b, want 0", start_tx); end
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = tx_obs.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL on_reply: got %h, want %h", o, e); end
    end
  endtask

  task automatic test_toggle();
    logic [7:0] cmds[3];
    logic       ens[3];
    cmds = '{8'h2A, 8'hC3, 8'hC3};
    ens  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h6B);
      send_byte(cmds[i], 1'b0);
      exp_en = ens[i];
      checks++; if (out_en !== exp_en) begin fails++; $display("FAIL toggle_out_en[%0d]: got %b, want %b", i, out_en, exp_en); end
      wait_replies(1, "toggle");
      while (exp_q.size() > 0 && tx_obs.size() > 0) begin
        logic [7:0] e, o;
        e = exp_q.pop_front(); o = tx_obs.pop_front();
        checks++; if (o !== e) begin fails++; $display("FAIL toggle_reply[%0d]: got %h, want %h", i, o, e); end
      end
    end
  endtask

  task automatic test_nack();
    int ce0;
    ce0 = ce_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'h55, 1'b0);
    checks++; if (out_en !== exp_en) begin fails++; $display("FAIL nack_unknown_out_en: got %b, want %b", out_en, exp_en); end
    checks++; if ({cmd_error, cmd_valid} !== 2'b10) begin fails++; $display("FAIL nack_unknown_flags: got %b, want 10", {cmd_error, cmd_valid}); end
    wait_replies(1, "nack1");
    exp_q.push_back(8'hA5);
    send_byte(8'h93, 1'b1);
    checks++; if (out_en !== exp_en) begin fails++; $display("FAIL nack_parity_out_en: got %b, want %b", out_en, exp_en); end
    wait_replies(2, "nack2");
    checks++; if (ce_cnt - ce0 !== 2) begin fails++; $display("FAIL nack_err_pulses: got %0d, want 2", ce_cnt - ce0); end
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = tx_obs.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL nack_reply: got %h, want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmds[3];
    logic       ens[3];
    int ov0, cv0;
    cmds = '{8'h2A, 8'h93, 8'h2A};
    ens  = '{1'b1, 1'b0, 1'b1};
    ov0 = ov_cnt; cv0 = cv_cnt;
    tx_stall = 1'b1;
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h6B);
    for (int i = 0; i < 3; i++) begin
      send_byte(cmds[i], 1'b0);
      exp_en = ens[i];
      checks++; if (out_en !== exp_en) begin fails++; $display("FAIL b2b_out_en[%0d]: got %b, want %b", i, out_en, exp_en); end
    end
    repeat (10) @(negedge clk);
    tx_stall = 1'b0;
    wait_replies(2, "b2b");
    repeat (10) @(negedge clk);
    checks++; if (tx_obs.size() !== 2) begin fails++; $display("FAIL b2b_reply_count: got %0d, want 2", tx_obs.size()); end
    checks++; if (ov_cnt - ov0 !== 1) begin fails++; $display("FAIL b2b_overrun: got %0d, want 1", ov_cnt - ov0); end
    checks++; if (cv_cnt - cv0 !== 3) begin fails++; $display("FAIL b2b_cmd_valid: got %0d, want 3", cv_cnt - cv0); end
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = tx_obs.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL b2b_reply: got %h, want %h", o, e); end
    end
    tx_obs.delete();
    exp_q.delete();
  endtask

  // Newest reply wins the pending slot: the TOGGLE ACK is replaced by a NACK.
  task automatic test_overwrite();
    tx_stall = 1'b1;
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'hA5);
    send_byte(8'h2A, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h55, 1'b0);
    exp_en = 1'b0;
    checks++; if (out_en !== exp_en) begin fails++; $display("FAIL ovw_out_en: got %b, want %b", out_en, exp_en); end
    repeat (6) @(negedge clk);
    tx_stall = 1'b0;
    wait_replies(2, "ovw");
    checks++; if (tx_obs.size() !== 2) begin fails++; $display("FAIL ovw_reply_count: got %0d, want 2", tx_obs.size()); end
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = tx_obs.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL ovw_reply: got %h, want %h", o, e); end
    end
    tx_obs.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    tx_stall = 1'b1;
    send_byte(8'h2A, 1'b0);
    send_byte(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (out_en !== 1'b0) begin fails++; $display("FAIL rstmid_out_en: got %b, want 0", out_en); end
    checks++; if (start_tx !== 1'b0) begin fails++; $display("FAIL rstmid_start_tx: got %b, want 0", start_tx); end
    checks++; if (data_to_tx !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h, want 00", data_to_tx); end
    tx_stall = 1'b0;
    tx_busy  = 1'b0;
    busy_cnt = 0;
    tx_obs.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    exp_en = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (tx_obs.size() !== 0) begin fails++; $display("FAIL rstmid_no_tx: got %0d replies, want 0", tx_obs.size()); end
  endtask

`ifdef UART_CMD_WATCHDOG_EN
  task automatic test_watchdog();
    int  trip0;
    logic bad_en;
    bad_en = 1'b0;
    trip0 = trip_cnt;
    send_byte(8'h2A, 1'b0);
    checks++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL wdt_cmd_valid: got %b, want 1", cmd_valid); end
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (out_en !== 1'b1 || wdt_trip !== 1'b0) bad_en = 1'b1;
    end
    checks++; if (bad_en !== 1'b0) begin fails++; $display("FAIL wdt_early: out_en or trip changed before cycle 100"); end
    @(negedge clk);
    checks++; if (out_en !== 1'b0) begin fails++; $display("FAIL wdt_expire_out_en: got %b, want 0", out_en); end
    checks++; if (wdt_trip !== 1'b1) begin fails++; $display("FAIL wdt_expire_trip: got %b, want 1", wdt_trip); end
    @(negedge clk);
    checks++; if (wdt_trip !== 1'b0) begin fails++; $display("FAIL wdt_trip_width: got %b, want 0", wdt_trip); end
    checks++; if (trip_cnt - trip0 !== 1) begin fails++; $display("FAIL wdt_trip_count: got %0d, want 1", trip_cnt - trip0); end
    send_byte(8'h2A, 1'b0);
    repeat (98) @(negedge clk);
    send_byte(8'h2A, 1'b0);
    checks++; if (out_en !== 1'b1) begin fails++; $display("FAIL wdt_rescue_out_en: got %b, want 1", out_en); end
    checks++; if (wdt_trip !== 1'b0) begin fails++; $display("FAIL wdt_rescue_trip: got %b, want 0", wdt_trip); end
    repeat (5) @(negedge clk);
    checks++; if (trip_cnt - trip0 !== 1) begin fails++; $display("FAIL wdt_rescue_count: got %0d, want 1", trip_cnt - trip0); end
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h6B);
    wait_replies(3, "wdt");
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = tx_obs.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL wdt_reply: got %h, want %h", o, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_on();
    test_toggle();
    test_nack();
    test_back_to_back();
    test_overwrite();
    test_reset_mid();
`ifdef UART_CMD_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
